// File: rtl/lif_spike_decoder.sv
// lif_spike_decoder: decays a weighted spike trace and counts spikes per window.
// Define LIF_DEC_ISI_EN to add the inter-spike-interval outputs isi/isi_valid.
module lif_spike_decoder #(
    parameter int DECAY_SHIFT  = 1,
    parameter int DECAY_PERIOD = 4,
    parameter int WINDOW       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       spike,
    input  logic [7:0] weight,
    output logic [7:0] current,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic [7:0] isi,
    output logic       isi_valid
);
    localparam int PW = DECAY_PERIOD > 1 ? $clog2(DECAY_PERIOD) : 1;
    localparam int WW = $clog2(WINDOW);

    logic [PW-1:0] pre_q, pre_d;
    logic [WW-1:0] win_q, win_d;
    logic [7:0]    trace_q, trace_d, cnt_q, cnt_d, rate_q, rate_d;
    logic          rv_q, rv_d;
    logic          tick, win_last;
    logic [7:0]    dec, t1, cnt_inc;
    logic [8:0]    sum;

    always_comb begin
        tick     = pre_q == PW'(DECAY_PERIOD - 1);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        dec      = trace_q >> DECAY_SHIFT;
        // Once the shift rounds to zero, step down by one so the trace always drains
        t1       = !tick ? trace_q : (dec != 8'd0 ? trace_q - dec : (trace_q != 8'd0 ? trace_q - 8'd1 : 8'd0));
        sum      = {1'b0, t1} + {1'b0, weight};
        trace_d  = !spike ? t1 : (sum[8] ? 8'hff : sum[7:0]);
        win_last = win_q == WW'(WINDOW - 1);
        win_d    = win_last ? '0 : win_q + 1'b1;
        cnt_inc  = (spike && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
        cnt_d    = win_last ? 8'd0 : cnt_inc;
        rate_d   = win_last ? cnt_inc : rate_q;
        rv_d     = ena && win_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            win_q   <= '0;
            trace_q <= 8'd0;
            cnt_q   <= 8'd0;
            rate_q  <= 8'd0;
            rv_q    <= 1'b0;
        end else begin
            rv_q <= rv_d;
            if (ena) begin
                pre_q   <= pre_d;
                win_q   <= win_d;
                trace_q <= trace_d;
                cnt_q   <= cnt_d;
                rate_q  <= rate_d;
            end
        end
    end

    assign current    = trace_q;
    assign rate       = rate_q;
    assign rate_valid = rv_q;

`ifdef LIF_DEC_ISI_EN
    logic [7:0] ivl_q, ivl_d, isi_q, isi_d;
    logic       seen_q, seen_d, iv_q, iv_d;

    always_comb begin
        seen_d = seen_q | spike;
        ivl_d  = spike ? 8'd0 : ((seen_q && ivl_q != 8'hff) ? ivl_q + 8'd1 : ivl_q);
        isi_d  = (spike && seen_q) ? (ivl_q == 8'hff ? 8'hff : ivl_q + 8'd1) : isi_q;
        iv_d   = ena && spike && seen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_q  <= 8'd0;
            isi_q  <= 8'd0;
            seen_q <= 1'b0;
            iv_q   <= 1'b0;
        end else begin
            iv_q <= iv_d;
            if (ena) begin
                ivl_q  <= ivl_d;
                isi_q  <= isi_d;
                seen_q <= seen_d;
            end
        end
    end

    assign isi       = isi_q;
    assign isi_valid = iv_q;
`else
    assign isi       = 8'd0;
    assign isi_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lif_spike_decoder.sv
// tb_lif_spike_decoder: scoreboard bench for the default decoder and a WINDOW=512 copy.
module tb_lif_spike_decoder;
    logic       clk = 0, rst_n = 1, ena = 0, spike = 0;
    logic [7:0] weight = 0;
    logic [7:0] current, rate, isi, cur_w, rate_w, isi_w;
    logic       rate_valid, isi_valid, rv_w, iv_w;
    int         checks = 0, errors = 0;
    int         pulses, save_cur, save_rate;
    int         seq [9] = '{50, 25, 13, 7, 4, 2, 1, 0, 0};

    always #5 clk = ~clk;

    lif_spike_decoder dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .weight(weight),
        .current(current), .rate(rate), .rate_valid(rate_valid), .isi(isi), .isi_valid(isi_valid)
    );

    lif_spike_decoder #(.WINDOW(512)) dut_w (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .weight(weight),
        .current(cur_w), .rate(rate_w), .rate_valid(rv_w), .isi(isi_w), .isi_valid(iv_w)
    );

    typedef struct {int cur, rate, rv, rate_w, rv_w, isi, iv;} exp_t;
    exp_t sb[$];
    int m_tr, m_pre, m_win, m_cnt, m_rate, m_win_w, m_cnt_w, m_rate_w, m_isi, m_ivl, m_seen;

    task automatic check(input string tag, input logic [15:0] got, input int exp);
        checks++;
        if (got !== 16'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        check("rst_current", current, 0);
        check("rst_rate", rate, 0);
        check("rst_rate_valid", rate_valid, 0);
        check("rst_isi", isi, 0);
        check("rst_isi_valid", isi_valid, 0);
        check("rst_rate_w", rate_w, 0);
        @(posedge clk);
        #1 rst_n = 1;
        {m_tr, m_pre, m_win, m_cnt, m_rate, m_win_w, m_cnt_w, m_rate_w, m_isi, m_ivl, m_seen} = '0;
    endtask

    task automatic cyc(input logic en, input logic sp, input int w);
        exp_t e;
        bit   tick;
        int   ci;
        ena = en; spike = sp; weight = 8'(w);
        e.rv = 0; e.rv_w = 0; e.iv = 0;
        if (en) begin
            tick  = m_pre == 3;
            m_pre = (m_pre + 1) % 4;
            if (tick) m_tr = (m_tr >> 1) != 0 ? m_tr - (m_tr >> 1) : (m_tr > 0 ? m_tr - 1 : 0);
            if (sp) m_tr = sat(m_tr + w);
            ci = sat(m_cnt + int'(sp));
            if (m_win == 15) begin m_rate = ci; m_cnt = 0; e.rv = 1; end else m_cnt = ci;
            m_win = (m_win + 1) % 16;
            ci = sat(m_cnt_w + int'(sp));
            if (m_win_w == 511) begin m_rate_w = ci; m_cnt_w = 0; e.rv_w = 1; end else m_cnt_w = ci;
            m_win_w = (m_win_w + 1) % 512;
            if (sp) begin
                if (m_seen != 0) begin m_isi = sat(m_ivl + 1); e.iv = 1; end
                m_ivl = 0; m_seen = 1;
            end else if (m_seen != 0) m_ivl = sat(m_ivl + 1);
        end
        e.cur = m_tr; e.rate = m_rate; e.rate_w = m_rate_w; e.isi = m_isi;
`ifndef LIF_DEC_ISI_EN
        e.isi = 0; e.iv = 0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("current", current, e.cur);
        check("rate", rate, e.rate);
        check("rate_valid", rate_valid, e.rv);
        check("current_w", cur_w, e.cur);
        check("rate_w", rate_w, e.rate_w);
        check("rate_valid_w", rv_w, e.rv_w);
        check("isi", isi, e.isi);
        check("isi_valid", isi_valid, e.iv);
    endtask

    initial begin
        @(posedge clk);
        #1 do_reset();
        cyc(1, 1, 100);
        check("decay_peak", current, 100);
        for (int i = 1; i < 36; i++) begin
            cyc(1, 0, 0);
            if (i % 4 == 3) check("decay_seq", current, seq[(i - 3) / 4]);
        end
        do_reset();
        cyc(1, 1, 200);
        cyc(1, 1, 200);
        check("trace_sat", current, 255);
        do_reset();
        cyc(1, 1, 100);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 10);
        check("decay_then_add", current, 60);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 48; i++) begin
            cyc(1, i % 4 == 0, 1);
            if (rate_valid) begin pulses++; check("rate4", rate, 4); end
        end
        check("rate4_pulses", pulses, 3);
        for (int i = 0; i < 16; i++) cyc(1, i % 4 == 0 || i == 15, 1);
        check("rate5", rate, 5);
        check("rate5_valid", rate_valid, 1);
        for (int i = 0; i < 16; i++) cyc(1, i % 4 == 0, 1);
        check("rate_restart", rate, 4);
        for (int i = 0; i < 5; i++) cyc(1, 1, 20);
        save_cur = current; save_rate = rate;
        for (int i = 0; i < 10; i++) cyc(0, 1'($urandom_range(1)), 50);
        check("freeze_current", current, save_cur);
        check("freeze_rate", rate, save_rate);
        for (int i = 0; i < 20; i++) cyc(1, i % 3 == 0, 30);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc(1, 1, 0);
            if (rv_w) begin pulses++; check("rate_w_sat", rate_w, 255); end
        end
        check("rate_w_pulses", pulses, 2);
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(1, i == 10 || i == 17, 5);
`ifdef LIF_DEC_ISI_EN
            if (i == 10) check("isi_first_none", isi_valid, 0);
            if (i == 17) begin check("isi7", isi, 7); check("isi7_valid", isi_valid, 1); end
`endif
        end
        for (int i = 0; i < 300; i++) cyc(1, 0, 0);
        cyc(1, 1, 5);
`ifdef LIF_DEC_ISI_EN
        check("isi_sat", isi, 255);
`endif
        for (int i = 0; i < 400; i++) cyc(1'($urandom_range(3) != 0), 1'($urandom_range(1)), int'($urandom_range(255)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
